// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access-size codes and
// the byte-lane mask helper used by the store merge path.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // One bit per byte lane of the 32-bit word touched by an access.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << offset;
      SZ_HALF: mask = 4'b0011 << offset;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath: extracts/extends load data from a memory word and
// merges right-aligned store data into the addressed byte lanes.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_mem_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [31:0] w_shifted;
  logic [31:0] w_repl;
  logic [3:0]  w_mask;

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    w_shifted = i_mem_word >> {i_offset, 3'b000};
    case (i_size)
      SZ_BYTE: o_load_data = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_load_data = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      SZ_WORD: o_load_data = w_shifted;
      default: o_load_data = 32'd0;
    endcase
  end

  // Store path: replicate the store data across lanes, keep only masked lanes.
  always_comb begin
    w_mask = lane_mask(i_size, i_offset);
    case (i_size)
      SZ_BYTE: w_repl = {4{i_wdata[7:0]}};
      SZ_HALF: w_repl = {2{i_wdata[15:0]}};
      default: w_repl = i_wdata;
    endcase
    o_merge_data = i_mem_word;
    for (int b = 0; b < 4; b++) begin
      o_merge_data[8*b +: 8] = w_mask[b] ? w_repl[8*b +: 8] : i_mem_word[8*b +: 8];
    end
  end

endmodule

// File: rtl/lsu_core.sv
// Load/store unit: one request at a time, sub-word stores done as a
// read-modify-write of the containing word, response held until accepted.
module lsu_core
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wr_dt_o,
  output logic              mem_wr_en_o,
  input  logic [31:0]       mem_rd_dt_i
);

  lsu_state_e         r_state;
  logic               r_we;
  logic               r_unsigned;
  logic [1:0]         r_size;
  logic [ADDR_W+1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic [31:0]        r_rdata;
  logic [31:0]        r_wr_dt;
  logic               r_wr_en;

  logic               w_accept;
  logic               w_addr_hi;
  logic               w_err;
  logic [31:0]        w_load;
  logic [31:0]        w_merge;

  assign req_ready_o = (r_state == IDLE);
  assign w_accept    = req_valid_i & req_ready_o;

  // Misalignment, illegal size, or an address beyond the memory all error out.
  always_comb begin
    w_addr_hi = (req_addr_i >> (ADDR_W + 2)) != 32'd0;
    case (req_size_i)
      SZ_BYTE: w_err = w_addr_hi;
      SZ_HALF: w_err = w_addr_hi | req_addr_i[0];
      SZ_WORD: w_err = w_addr_hi | (req_addr_i[1:0] != 2'b00);
      default: w_err = 1'b1;
    endcase
  end

  lsu_align u_align (
    .i_mem_word   (mem_rd_dt_i),
    .i_offset     (r_addr[1:0]),
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load),
    .o_merge_data (w_merge)
  );

  // Access sequencer with registered handshake and memory-side outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= 2'b00;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= 32'd0;
      r_wr_dt     <= 32'd0;
      r_wr_en     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we       <= req_we_i;
            r_unsigned <= req_unsigned_i;
            r_size     <= req_size_i;
            r_addr     <= req_addr_i[ADDR_W+1:0];
            r_wdata    <= req_wdata_i;
            r_rdata    <= 32'd0;
            if (w_err) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else if (!req_we_i) begin
              r_state <= LOAD;
            end else if (req_size_i == SZ_WORD) begin
              r_state <= WRITE;
              r_wr_dt <= req_wdata_i;
              r_wr_en <= 1'b1;
            end else begin
              r_state <= MERGE;
            end
          end
        end
        LOAD: begin
          r_rdata     <= r_we ? 32'd0 : w_load;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        MERGE: begin
          r_wr_dt <= w_merge;
          r_wr_en <= 1'b1;
          r_state <= WRITE;
        end
        WRITE: begin
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata     <= 32'd0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_rdata_o = r_rdata;
  assign mem_wr_dt_o = r_wr_dt;
  assign mem_wr_en_o = r_wr_en;
  assign mem_addr_o  = (r_state == IDLE) ? {ADDR_W{1'b0}} : r_addr[ADDR_W+1:2];

endmodule

// File: tb/tb_lsu_core.sv
// Self-checking bench for lsu_core: directed vector table, multi-cycle corner
// sequences, and randomized accesses against a byte-level memory model.
module tb_lsu_core;

  localparam int ADDR_W = 8;
  localparam int NWORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_uns = 1'b0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wr_dt;
  logic              mem_wr_en;
  logic [31:0]       mem_rd_dt;

  logic [31:0] mem     [NWORDS];
  logic [31:0] ref_mem [NWORDS];
  int wr_count = 0;
  int wr_in_reset = 0;
  int nvec = 0;
  int nfail = 0;

  lsu_core #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .mem_addr_o(mem_addr),
    .mem_wr_dt_o(mem_wr_dt), .mem_wr_en_o(mem_wr_en), .mem_rd_dt_i(mem_rd_dt)
  );

  always #5 clk = ~clk;

  assign mem_rd_dt = mem[mem_addr];

  // Data memory; a write with reset asserted is recorded as a violation.
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_dt;
      wr_count <= wr_count + 1;
      if (!rst_n) wr_in_reset <= wr_in_reset + 1;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] want_rdata;
    logic        want_err;
    int          want_lat;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input int lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.want_rdata = rdata; v.want_err = err; v.want_lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Issue one request and collect its response, latency and write-pulse count.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int rdly,
                        output logic [31:0] rdata, output logic err, output int lat, output int nwr);
    int w0;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    w0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    repeat (rdly) @(posedge clk);
    #1;
    rdata = rsp_rdata;
    err = rsp_err;
    nwr = wr_count - w0;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // Reference: byte-addressed memory semantics computed with plain arithmetic.
  task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int lat, output int nwr);
    int nb, off, idx;
    logic [31:0] w, mask;
    nb = 1 << size;
    off = int'(addr % 32'd4);
    idx = int'(addr / 32'd4);
    err = (size == 2'd3) || ((addr % nb) != 0) || (addr >= (32'd1 << (ADDR_W + 2)));
    rdata = 32'd0; lat = 1; nwr = 0;
    if (!err) begin
      w = ref_mem[idx];
      if (we) begin
        for (int b = 0; b < nb; b++) begin
          w = w & ~(32'hFF << (8 * (off + b)));
          w = w | (((wdata >> (8 * b)) & 32'hFF) << (8 * (off + b)));
        end
        ref_mem[idx] = w;
        nwr = 1;
        lat = (nb == 4) ? 2 : 3;
      end else begin
        rdata = w >> (8 * off);
        if (nb < 4) begin
          mask = (32'd1 << (8 * nb)) - 32'd1;
          rdata = rdata & mask;
          if (!uns && rdata[8 * nb - 1]) rdata = rdata | ~mask;
        end
        lat = 2;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, e_rd, hold;
    logic        er, e_er;
    int          lat, nwr, e_lat, e_nwr, w0, idx;
    logic        we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    for (int i = 0; i < NWORDS; i++) mem[i] = 32'd0;
    mem[8] = 32'h0BADF00D;

    tbl[0]  = mk(1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2);
    tbl[1]  = mk(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2);
    tbl[2]  = mk(1'b1, 2'b00, 1'b0, 32'h11,  32'h55,       32'h0,        1'b0, 3);
    tbl[3]  = mk(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEAD55EF, 1'b0, 2);
    tbl[4]  = mk(1'b1, 2'b10, 1'b0, 32'h10,  32'h8000F0A5, 32'h0,        1'b0, 2);
    tbl[5]  = mk(1'b0, 2'b00, 1'b0, 32'h10,  32'h0,        32'hFFFFFFA5, 1'b0, 2);
    tbl[6]  = mk(1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        32'h00008000, 1'b0, 2);
    tbl[7]  = mk(1'b0, 2'b01, 1'b0, 32'h12,  32'h0,        32'hFFFF8000, 1'b0, 2);
    tbl[8]  = mk(1'b0, 2'b10, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1, 1);
    tbl[9]  = mk(1'b1, 2'b01, 1'b0, 32'h13,  32'h1234,     32'h0,        1'b1, 1);
    tbl[10] = mk(1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1, 1);
    tbl[11] = mk(1'b0, 2'b10, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1, 1);
    tbl[12] = mk(1'b1, 2'b00, 1'b0, 32'h13,  32'hAB,       32'h0,        1'b0, 3);
    tbl[13] = mk(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hAB00F0A5, 1'b0, 2);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("reset mem_wr_dt", mem_wr_dt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready after reset", {31'd0, req_ready}, 32'd1);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      do_req(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, i % 2, rd, er, lat, nwr);
      chk($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, tbl[i].want_err});
      chk($sformatf("vec%0d rdata", i), rd, tbl[i].want_rdata);
      chk($sformatf("vec%0d latency", i), lat, tbl[i].want_lat);
      chk($sformatf("vec%0d writes", i), nwr, (tbl[i].we && !tbl[i].want_err) ? 32'd1 : 32'd0);
      if (i == 2) chk("byte merge mem[4]", mem[4], 32'hDEAD55EF);
    end

    // Backpressure: response held, no new request accepted
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0; req_addr = 32'h10; req_wdata = 32'd0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp rdata", rsp_rdata, 32'hAB00F0A5);
    w0 = wr_count;
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h11111111; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp rdata stable", rsp_rdata, 32'hAB00F0A5);
      chk("bp req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp rsp released", {31'd0, rsp_valid}, 32'd0);
    chk("bp ready again", {31'd0, req_ready}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("bp no store", mem[8], 32'h0BADF00D);
    chk("bp no write", wr_count - w0, 32'd0);

    // Reset while in MERGE aborts the read-modify-write
    w0 = wr_count;
    hold = mem[4];
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h77; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("mrst mem_addr", {24'd0, mem_addr}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("mrst mem unchanged", mem[4], hold);
    chk("mrst no write", wr_count - w0, 32'd0);
    chk("writes in reset", wr_in_reset, 32'd0);

    // Randomized accesses against the reference model
    for (int i = 0; i < NWORDS; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom % 2);
      uns = 1'($urandom % 2);
      size = ($urandom % 16 == 0) ? 2'd3 : 2'($urandom % 3);
      addr = ($urandom % 16) * 4 + ($urandom % 4);
      if ($urandom % 8 != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      if ($urandom % 16 == 0) addr = addr | (32'd1 << (10 + ($urandom % 22)));
      wdata = $urandom;
      ref_access(we, size, uns, addr, wdata, e_rd, e_er, e_lat, e_nwr);
      do_req(we, size, uns, addr, wdata, int'($urandom % 3), rd, er, lat, nwr);
      chk($sformatf("rnd%0d err", n), {31'd0, er}, {31'd0, e_er});
      chk($sformatf("rnd%0d rdata", n), rd, e_rd);
      chk($sformatf("rnd%0d latency", n), lat, e_lat);
      chk($sformatf("rnd%0d writes", n), nwr, e_nwr);
      if (we && !e_er) begin
        idx = int'(addr / 32'd4);
        chk($sformatf("rnd%0d mem", n), mem[idx], ref_mem[idx]);
      end
    end
    chk("final writes in reset", wr_in_reset, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
